// File: rtl/hash_frame_tx.sv
// Transmit framer: pulls a latched number of bytes from the hash FIFO and emits
// SYNC0, SYNC1, LENH, LENL, payload, XOR checksum on a valid/ready byte stream.
module hash_frame_tx #(
    parameter logic [7:0] SYNC0 = 8'h55,
    parameter logic [7:0] SYNC1 = 8'hD5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        txStart,
    input  logic [10:0] txByteTotal,
    input  logic [7:0]  hashData,
    input  logic        hashFifoEmpty,
    input  logic        hashFifoValid,
    output logic        hashRdEn,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        txBusy,
    output logic        frameDone
);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC0, S_SYNC1, S_LENH, S_LENL,
        S_FETCH, S_WAITV, S_SEND, S_CSUM, S_DONE
    } state_t;

    state_t      state, state_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [10:0] remaining, remaining_d;
    logic [10:0] len, len_d;
    logic [7:0]  csum, csum_d;
    logic        accept;
    logic [7:0]  len_hi;

    assign accept    = valid_q & txReady;
    assign len_hi    = {5'b0, len[10:8]};
    assign txData    = data_q;
    assign txValid   = valid_q;
    assign txBusy    = (state != S_IDLE);
    assign frameDone = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            remaining <= '0;
            len       <= '0;
            csum      <= '0;
        end else begin
            state     <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            remaining <= remaining_d;
            len       <= len_d;
            csum      <= csum_d;
        end
    end

    // The outgoing byte is loaded on the transition into each emitting state,
    // so txData/txValid stay registered and hold steady while stalled.
    always_comb begin
        state_d     = state;
        data_d      = data_q;
        valid_d     = valid_q;
        remaining_d = remaining;
        len_d       = len;
        csum_d      = csum;
        hashRdEn    = 1'b0;
        case (state)
            S_IDLE: begin
                if (txStart) begin
                    remaining_d = txByteTotal;
                    len_d       = txByteTotal;
                    csum_d      = '0;
                    data_d      = SYNC0;
                    valid_d     = 1'b1;
                    state_d     = S_SYNC0;
                end
            end
            S_SYNC0: begin
                if (accept) begin
                    data_d  = SYNC1;
                    state_d = S_SYNC1;
                end
            end
            S_SYNC1: begin
                if (accept) begin
                    data_d  = len_hi;
                    csum_d  = csum ^ len_hi;
                    state_d = S_LENH;
                end
            end
            S_LENH: begin
                if (accept) begin
                    data_d  = len[7:0];
                    csum_d  = csum ^ len[7:0];
                    state_d = S_LENL;
                end
            end
            S_LENL: begin
                if (accept) begin
                    if (len != '0) begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        data_d  = csum;
                        state_d = S_CSUM;
                    end
                end
            end
            S_FETCH: begin
                hashRdEn = !hashFifoEmpty;
                if (!hashFifoEmpty) state_d = S_WAITV;
            end
            S_WAITV: begin
                if (hashFifoValid) begin
                    data_d  = hashData;
                    valid_d = 1'b1;
                    csum_d  = csum ^ hashData;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (accept) begin
                    remaining_d = remaining - 11'd1;
                    if (remaining == 11'd1) begin
                        data_d  = csum;
                        state_d = S_CSUM;
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hash_frame_tx.sv
// Scoreboard bench for hash_frame_tx: a FIFO model feeds payload, expected
// frame bytes are queued at load time and popped as the sink accepts bytes.
module tb_hash_frame_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        txStart;
    logic [10:0] txByteTotal;
    logic [7:0]  hashData = 8'h00;
    logic        hashFifoEmpty;
    logic        hashFifoValid = 1'b0;
    logic        hashRdEn;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b1;
    logic        txBusy;
    logic        frameDone;

    logic        force_empty = 1'b0;
    logic        fifo_empty_r = 1'b1;
    logic        rand_ready = 1'b0;
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h00;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          rd_count = 0;
    int          acc_count = 0;

    hash_frame_tx #(.SYNC0(8'h55), .SYNC1(8'hD5)) dut (
        .clk(clk), .reset_n(reset_n), .txStart(txStart), .txByteTotal(txByteTotal),
        .hashData(hashData), .hashFifoEmpty(hashFifoEmpty), .hashFifoValid(hashFifoValid),
        .hashRdEn(hashRdEn), .txData(txData), .txValid(txValid), .txReady(txReady),
        .txBusy(txBusy), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    assign hashFifoEmpty = force_empty | fifo_empty_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // FIFO model with one cycle read latency
    always @(posedge clk) begin
        hashFifoValid <= 1'b0;
        if (hashRdEn) begin
            rd_count++;
            if (fifo_q.size() != 0) hashData <= fifo_q.pop_front();
            hashFifoValid <= 1'b1;
        end
    end

    always @(negedge clk) fifo_empty_r = (fifo_q.size() == 0);

    // Sink: chooses txReady for the coming edge, then scores the accepted byte
    always @(negedge clk) begin
        if (reset_n) begin
            if (stalled) begin
                check("stall_valid", txValid, 1);
                check("stall_data", txData, held);
            end
            txReady = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            stalled = txValid && !txReady;
            held    = txData;
            if (txValid && txReady) begin
                acc_count++;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_byte", txData, exp_q.pop_front());
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic load(input int n, input int base);
        logic [7:0]  b, cs;
        logic [10:0] l;
        l  = n[10:0];
        cs = {5'b0, l[10:8]} ^ l[7:0];
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        exp_q.push_back({5'b0, l[10:8]});
        exp_q.push_back(l[7:0]);
        for (int i = 0; i < n; i++) begin
            b = 8'((base + i) & 255);
            fifo_q.push_back(b);
            exp_q.push_back(b);
            cs ^= b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        txByteTotal = n[10:0];
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        txByteTotal = '0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (frameDone !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", frameDone, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rden"}, hashRdEn, 0);
        check({tag, "_valid"}, txValid, 0);
        check({tag, "_data"}, txData, 0);
        check({tag, "_busy"}, txBusy, 0);
        check({tag, "_done"}, frameDone, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, r0, a0, t;
        reset_n = 1'b0;
        txStart = 1'b0;
        txByteTotal = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // N=80, always ready
        r0 = rd_count;
        load(80, 0);
        pulse_start(80);
        check("c1_valid", txValid, 1);
        check("c1_data", txData, 8'h55);
        check("c1_busy", txBusy, 1);
        wait_done(cyc);
        check("n80_done_cycle", cyc, 246);
        @(negedge clk);
        check("n80_busy_after", txBusy, 0);
        check("n80_reads", rd_count - r0, 80);
        check("n80_sb_empty", exp_q.size(), 0);

        // N=80, random backpressure
        rand_ready = 1'b1;
        r0 = rd_count;
        load(80, 0);
        pulse_start(80);
        wait_done(cyc);
        rand_ready = 1'b0;
        check("rnd_reads", rd_count - r0, 80);
        check("rnd_sb_empty", exp_q.size(), 0);

        // zero length; a start during DONE must be dropped
        r0 = rd_count;
        load(0, 0);
        pulse_start(0);
        wait_done(cyc);
        check("n0_done_cycle", cyc, 6);
        txStart = 1'b1;
        txByteTotal = 11'd7;
        @(negedge clk);
        txStart = 1'b0;
        check("done_start_busy", txBusy, 0);
        check("done_start_valid", txValid, 0);
        @(negedge clk);
        check("done_start_busy2", txBusy, 0);
        check("n0_reads", rd_count - r0, 0);
        check("n0_sb_empty", exp_q.size(), 0);

        // FIFO starved for 10 cycles after the header
        force_empty = 1'b1;
        r0 = rd_count;
        a0 = acc_count;
        load(4, 1);
        pulse_start(4);
        t = 0;
        while (acc_count < a0 + 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hdr_seen", acc_count - a0, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_rden", hashRdEn, 0);
            check("starve_busy", txBusy, 1);
        end
        force_empty = 1'b0;
        wait_done(cyc);
        check("starve_reads", rd_count - r0, 4);
        check("starve_sb_empty", exp_q.size(), 0);

        // mid-frame start ignored, then a new frame of 5
        r0 = rd_count;
        load(8, 8'h10);
        pulse_start(8);
        repeat (6) @(negedge clk);
        txStart = 1'b1;
        txByteTotal = 11'd5;
        @(negedge clk);
        txStart = 1'b0;
        txByteTotal = '0;
        wait_done(cyc);
        check("ign_reads", rd_count - r0, 8);
        check("ign_sb_empty", exp_q.size(), 0);
        r0 = rd_count;
        load(5, 8'h20);
        pulse_start(5);
        check("n5_c1_data", txData, 8'h55);
        wait_done(cyc);
        check("n5_done_cycle", cyc, 21);
        check("n5_reads", rd_count - r0, 5);
        check("n5_sb_empty", exp_q.size(), 0);

        // reset during payload byte 30
        a0 = acc_count;
        load(40, 8'h80);
        pulse_start(40);
        t = 0;
        while (acc_count < a0 + 34 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_progress", acc_count - a0 >= 34, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        fifo_q.delete();
        r0 = rd_count;
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_reads", rd_count - r0, 0);
        check("post_reset_busy", txBusy, 0);
        r0 = rd_count;
        load(3, 8'hA0);
        pulse_start(3);
        check("rst_c1_data", txData, 8'h55);
        wait_done(cyc);
        check("rst_reads", rd_count - r0, 3);
        check("rst_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
